lut_prog: RTL and testbench
===========================

LUT_PROG -- requirements
Module: lut_prog

Interface
REQ-001 Parameter N, default 5, number of LUT select inputs (1..6).
REQ-002 Parameter INIT, default 32'h7BE6_4D5E, 2**N-bit reset truth table; bit i = output for minterm i (default: OFF set {0,5,7,9,12,13,15,16,19,20,26,31}).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  evaluation request.
REQ-006 in_a  input  N  minterm index to evaluate.
REQ-007 in_ready  output  1  evaluation request accepted when in_valid & in_ready.
REQ-008 out_valid  output  1  one-cycle pulse, out_y valid.
REQ-009 out_y  output  1  registered LUT result.
REQ-010 cfg_start  input  1  begin loading a new truth table.
REQ-011 cfg_valid  input  1  cfg_bit carries one table bit this cycle.
REQ-012 cfg_bit  input  1  serial table bit, minterm 0 first.
REQ-013 cfg_busy  output  1  high while in LOAD.
REQ-014 cfg_done  output  1  one-cycle pulse when the new table is committed.

Function
REQ-015 States SHALL be IDLE and LOAD; reset state IDLE.
REQ-016 in_ready SHALL be 1 in IDLE and 0 in LOAD (combinational from state).
REQ-017 An accepted request in cycle k SHALL give out_valid=1 and out_y=table[in_a] in cycle k+1 (latency 1, no backpressure).
REQ-018 out_valid SHALL be 0 in any cycle not following an accept; out_y SHALL hold its last value when out_valid=0.
REQ-019 IDLE + cfg_start SHALL go to LOAD, clear bit counter to 0, clear shadow register.
REQ-020 A request accepted in the same cycle as cfg_start SHALL use the old table.
REQ-021 In LOAD, each cfg_valid cycle SHALL write cfg_bit into shadow[count] and increment count; cycles with cfg_valid=0 SHALL hold state.
REQ-022 When cfg_valid and count = 2**N-1, the active table SHALL be replaced by the full shadow contents (all 2**N bits at once) at that edge, state SHALL return to IDLE, cfg_done SHALL pulse in the next cycle.
REQ-023 The table SHALL never be partially updated; evaluations always see either the complete old or the complete new table.
REQ-024 cfg_start during LOAD SHALL restart the load (count=0, shadow cleared, table unchanged); cfg_start has priority over cfg_valid in that cycle.
REQ-025 cfg_valid/cfg_bit in IDLE without cfg_start SHALL be ignored.
REQ-026 in_valid during LOAD SHALL not be accepted and SHALL produce no out_valid.
REQ-027 Bit counter width SHALL be N+1 bits; no wrap past 2**N-1.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, table=INIT, shadow=0, count=0, out_valid=0, out_y=0, cfg_done=0, cfg_busy=0.
REQ-029 Reset asserted during LOAD SHALL abandon the load; table SHALL revert to INIT, not to the last committed table.
REQ-030 After rst_n rises, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-031 Default INIT, sweep in_a=0..31 one per cycle -> out_y=0 exactly for 0,5,7,9,12,13,15,16,19,20,26,31, else 1, each one cycle later.
REQ-032 Load 32 bits all 1 with gaps in cfg_valid -> cfg_busy high throughout, cfg_done pulses once, then in_a=0 -> out_y=1.
REQ-033 Load half of table, assert cfg_start again, load 32'h0000_0001 -> in_a=0 gives 1, in_a=5 gives 0; no partial table ever seen.
REQ-034 in_valid held during LOAD -> in_ready=0, no out_valid until return to IDLE; request with cfg_start in same cycle uses old table.
REQ-035 Load all zeros, then reset mid-second load -> in_a=1 gives 1 (INIT restored), all outputs 0 during reset.
REQ-036 N=3, INIT=8'hA5 -> in_a=0..7 gives 1,0,1,0,0,1,0,1; 8-bit load commits after 8th cfg_valid.

Source files
------------

// File: rtl/lut_prog.sv
// Runtime-reprogrammable LUT: registered single-bit lookup of a 2**N-entry truth table,
// reloaded through a serial shadow register that commits the whole table atomically.
module lut_prog #(
  parameter int                N    = 5,
  parameter logic [(1<<N)-1:0] INIT = 32'h7BE6_4D5E
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_a,
  output logic         in_ready,
  output logic         out_valid,
  output logic         out_y,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_busy,
  output logic         cfg_done
);

  localparam int unsigned DEPTH = 1 << N;
  localparam logic [N:0]  LAST  = (N+1)'(DEPTH - 1);
  localparam logic [N:0]  ONE   = (N+1)'(1);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [N:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             out_y_q, out_y_d;
  logic             cfg_done_q, cfg_done_d;
  logic             accept;

  // Handshake: a request transfers on any rising edge where in_valid && in_ready;
  // there is no output backpressure, so the result always appears one cycle later.
  assign in_ready  = (state_q == IDLE);
  assign cfg_busy  = (state_q == LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign cfg_done  = cfg_done_q;

  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    shadow_d    = shadow_q;
    count_d     = count_q;
    cfg_done_d  = 1'b0;
    out_valid_d = accept;
    out_y_d     = accept ? table_q[in_a] : out_y_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = LOAD;
          count_d  = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        // A restart wins over a data bit arriving in the same cycle.
        if (cfg_start) begin
          count_d  = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          shadow_d[count_q[N-1:0]] = cfg_bit;
          if (count_q == LAST) begin
            table_d    = shadow_d;
            state_d    = IDLE;
            count_d    = '0;
            cfg_done_d = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      table_q     <= INIT;
      shadow_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

endmodule

// File: tb/tb_lut_prog.sv
// Directed bench for lut_prog: default 5-input instance plus a 3-input instance with INIT 8'hA5.
module tb_lut_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, cfg_start, cfg_valid, cfg_bit;
  logic [4:0] in_a;
  logic       in_ready, out_valid, out_y, cfg_busy, cfg_done;
  logic       b_in_valid, b_cfg_start, b_cfg_valid, b_cfg_bit;
  logic [2:0] b_in_a;
  logic       b_in_ready, b_out_valid, b_out_y, b_cfg_busy, b_cfg_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lut_prog dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_ready(in_ready),
    .out_valid(out_valid), .out_y(out_y), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  lut_prog #(.N(3), .INIT(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_a(b_in_a), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_y(b_out_y), .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid),
    .cfg_bit(b_cfg_bit), .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs set before a step are sampled at its rising edge; outputs are checked 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_default(input int a);
    return !(a inside {0, 5, 7, 9, 12, 13, 15, 16, 19, 20, 26, 31});
  endfunction

  task automatic eval(input string tag, input int a, input logic exp);
    in_valid = 1'b1;
    in_a     = 5'(a);
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_y"}, out_y, exp);
  endtask

  // Start a load (with a competing data bit to exercise start priority), then shift nbits of w.
  task automatic load_word(input logic [31:0] w, input int nbits, input int gap);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("load_start_busy", cfg_busy, 1'b1);
    chk("load_start_ready", in_ready, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (gap > 0 && (i % 3) == 0) begin
        cfg_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        chk("load_gap_busy", cfg_busy, 1'b1);
      end
      cfg_valid = 1'b1;
      cfg_bit   = w[i];
      step();
      if (i == 31) begin
        chk("load_commit_busy", cfg_busy, 1'b0);
        chk("load_commit_done", cfg_done, 1'b1);
        chk("load_commit_ready", in_ready, 1'b1);
        chk("load_commit_no_out", out_valid, 1'b0);
      end else begin
        chk("load_bit_busy", cfg_busy, 1'b1);
        chk("load_bit_done", cfg_done, 1'b0);
        chk("load_bit_ready", in_ready, 1'b0);
        chk("load_bit_no_out", out_valid, 1'b0);
      end
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    if (nbits == 32) begin
      step();
      chk("load_done_pulse_end", cfg_done, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] b_init;
    logic [7:0] b_new;
    b_init = 8'hA5;
    b_new  = 8'h3C;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    b_in_valid = 1'b0; b_in_a = '0; b_cfg_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_bit = 1'b0;

    // Reset state
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_y", out_y, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Default truth table sweep, one request per cycle
    in_valid = 1'b1;
    for (int a = 0; a < 32; a++) begin
      in_a = 5'(a);
      step();
      chk($sformatf("sweep_valid_%0d", a), out_valid, 1'b1);
      chk($sformatf("sweep_y_%0d", a), out_y, exp_default(a));
    end
    in_valid = 1'b0;
    step();
    chk("idle_no_valid", out_valid, 1'b0);
    eval("eval_a1", 1, 1'b1);
    step();
    chk("hold_valid", out_valid, 1'b0);
    chk("hold_y", out_y, 1'b1);

    // Config bits in IDLE without a start are ignored
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_cfg_busy", cfg_busy, 1'b0);
      chk("idle_cfg_done", cfg_done, 1'b0);
    end
    cfg_valid = 1'b0;
    eval("idle_cfg_keep1", 1, 1'b1);
    eval("idle_cfg_keep0", 0, 1'b0);

    // All-ones load with gaps
    load_word(32'hFFFF_FFFF, 32, 2);
    eval("ones_a0", 0, 1'b1);
    eval("ones_a5", 5, 1'b1);

    // Partial load, restart, then load 32'h1
    load_word(32'h0000_0000, 16, 0);
    load_word(32'h0000_0001, 32, 0);
    eval("restart_a0", 0, 1'b1);
    eval("restart_a5", 5, 1'b0);
    eval("restart_a1", 1, 1'b0);

    // Request in the start cycle uses the old table; held request blocked during LOAD
    in_valid = 1'b1;
    in_a     = 5'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("start_cycle_valid", out_valid, 1'b1);
    chk("start_cycle_old_y", out_y, 1'b1);
    chk("start_cycle_busy", cfg_busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_ready", in_ready, 1'b0);
      chk("held_no_out", out_valid, 1'b0);
    end
    load_word(32'hFFFF_FFFE, 32, 1);
    chk("held_after_commit_valid", out_valid, 1'b1);
    chk("held_after_commit_y", out_y, 1'b0);
    in_valid = 1'b0;
    step();

    // All-zeros load, then reset in the middle of a second load
    load_word(32'h0000_0000, 32, 0);
    eval("zeros_a1", 1, 1'b0);
    load_word(32'hFFFF_FFFF, 10, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", cfg_busy, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_y", out_y, 1'b0);
    chk("midrst_done", cfg_done, 1'b0);
    step();
    chk("midrst_hold_busy", cfg_busy, 1'b0);
    rst_n = 1'b1;
    eval("after_rst_a1", 1, 1'b1);
    eval("after_rst_a0", 0, 1'b0);
    eval("after_rst_a26", 26, 1'b0);

    // Three-input instance: INIT sweep then an 8-bit load
    b_in_valid = 1'b1;
    for (int a = 0; a < 8; a++) begin
      b_in_a = 3'(a);
      step();
      chk($sformatf("b_sweep_valid_%0d", a), b_out_valid, 1'b1);
      chk($sformatf("b_sweep_y_%0d", a), b_out_y, b_init[a]);
    end
    b_in_valid = 1'b0;
    b_cfg_start = 1'b1;
    step();
    b_cfg_start = 1'b0;
    chk("b_start_busy", b_cfg_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b_cfg_valid = 1'b1;
      b_cfg_bit   = b_new[i];
      step();
      chk($sformatf("b_load_busy_%0d", i), b_cfg_busy, (i == 7) ? 1'b0 : 1'b1);
      chk($sformatf("b_load_done_%0d", i), b_cfg_done, (i == 7) ? 1'b1 : 1'b0);
    end
    b_cfg_valid = 1'b0;
    step();
    chk("b_done_end", b_cfg_done, 1'b0);
    b_in_valid = 1'b1;
    for (int a = 0; a < 8; a++) begin
      b_in_a = 3'(a);
      step();
      chk($sformatf("b_new_y_%0d", a), b_out_y, b_new[a]);
    end
    b_in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
